// File: rtl/shift_serializer_pkg.sv
// -----------------------------------------------------------------------------
// shift_serializer_pkg
// Shared definitions for the parallel-in / serial-out transmitter:
//   - state_e   : FSM encoding (IDLE = 1'b0, SHIFT = 1'b1)
//   - cnt_width : bit-counter width, max(1, clog2(width))
// -----------------------------------------------------------------------------
package shift_serializer_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   // A one-bit word still needs a one-bit counter, so clog2 is clamped at 1.
   function automatic int cnt_width(input int width);
      return (width <= 1) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/shift_serializer_bit_counter.sv
// -----------------------------------------------------------------------------
// shift_serializer_bit_counter
// Modulo-WIDTH up-counter tracking which bit of the word is on the wire.
// Ports:
//   clk   in   clock, rising edge
//   rst   in   synchronous active-high reset (count -> 0)
//   clr   in   force count to 0; wins over inc
//   inc   in   advance count by one, wrapping WIDTH-1 -> 0
//   count out  current count
//   term  out  count == WIDTH-1
// -----------------------------------------------------------------------------
module shift_serializer_bit_counter
   import shift_serializer_pkg::*;
#(
   parameter  int WIDTH = 5,
   localparam int CW    = cnt_width(WIDTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          inc,
   output logic [CW-1:0] count,
   output logic          term
);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   assign term  = (count_q == CW'(WIDTH - 1));
   assign count = count_q;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc) begin
         count_d = term ? '0 : count_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/shift_serializer.sv
// -----------------------------------------------------------------------------
// shift_serializer
// Parallel-in, serial-out transmitter, LSB first, one bit per accepted cycle.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   load_valid    in   upstream offers data_in
//   load_ready    out  a word can be taken this cycle
//   data_in       in   parallel word, sampled only on a load handshake
//   ser_out       out  current serial bit (sreg[0])
//   ser_valid     out  ser_out carries a bit of a held word
//   ser_last      out  current bit is bit WIDTH-1
//   ser_ready     in   downstream takes the current bit this cycle
//   dbg_state     out  FSM state, for observation only
//   dbg_cnt       out  bit counter, for observation only
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. valid never depends on ready; load_ready may depend on
// ser_ready so that a new word can replace the word whose last bit leaves
// in the same cycle (no bubble between words).
// -----------------------------------------------------------------------------
module shift_serializer
   import shift_serializer_pkg::*;
#(
   parameter  int WIDTH = 5,
   localparam int CW    = cnt_width(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] data_in,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             ser_last,
   input  logic             ser_ready,
   output state_e           dbg_state,
   output logic [CW-1:0]    dbg_cnt
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic             cnt_clr;
   logic             cnt_inc;
   logic             cnt_term;
   logic [CW-1:0]    cnt;
   logic             bit_fire;
   logic             load_fire;

   shift_serializer_bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr),
      .inc   (cnt_inc),
      .count (cnt),
      .term  (cnt_term)
   );

   assign ser_valid  = (state_q == SHIFT);
   assign ser_last   = ser_valid && cnt_term;
   assign ser_out    = sreg_q[0];
   assign bit_fire   = ser_valid && ser_ready;
   assign load_ready = !ser_valid || (bit_fire && ser_last);
   assign load_fire  = load_valid && load_ready;
   assign dbg_state  = state_q;
   assign dbg_cnt    = cnt;

   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
      if (load_fire) begin
         // Covers both an idle load and a reload on the last accepted bit.
         state_d = SHIFT;
         sreg_d  = data_in;
         cnt_clr = 1'b1;
      end else if (bit_fire) begin
         if (ser_last) begin
            state_d = IDLE;
         end else begin
            sreg_d  = sreg_q >> 1;
            cnt_inc = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sreg_q  <= '0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
      end
   end

endmodule

// File: tb/tb_shift_serializer.sv
module tb_shift_serializer;
  import shift_serializer_pkg::*;

  localparam int W = 5;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         load_valid = 1'b0;
  logic         load_ready;
  logic [W-1:0] data_in = '0;
  logic         ser_out, ser_valid, ser_last;
  logic         ser_ready = 1'b0;
  state_e       dbg_state;
  logic [2:0]   dbg_cnt;

  logic         rst1 = 1'b1;
  logic         load_valid1 = 1'b0;
  logic         load_ready1;
  logic [0:0]   data_in1 = '0;
  logic         ser_out1, ser_valid1, ser_last1;
  logic         ser_ready1 = 1'b0;
  state_e       dbg_state1;
  logic [0:0]   dbg_cnt1;

  shift_serializer #(.WIDTH(W)) u_dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .data_in(data_in), .ser_out(ser_out), .ser_valid(ser_valid),
    .ser_last(ser_last), .ser_ready(ser_ready),
    .dbg_state(dbg_state), .dbg_cnt(dbg_cnt)
  );

  shift_serializer #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst1), .load_valid(load_valid1), .load_ready(load_ready1),
    .data_in(data_in1), .ser_out(ser_out1), .ser_valid(ser_valid1),
    .ser_last(ser_last1), .ser_ready(ser_ready1),
    .dbg_state(dbg_state1), .dbg_cnt(dbg_cnt1)
  );

  int checks = 0;
  int failures = 0;

  // scoreboard: {last, bit} expected per emitted bit
  logic [1:0] exp_q[$];

  typedef struct {
    logic         rst;
    logic         lv;
    logic [W-1:0] din;
    logic         sr;
    logic         chk_out;
    logic         eo;
    logic         ev;
    logic         el;
    logic         elr;
  } vec_t;

  vec_t vecs[$];

  function automatic void av(input logic r, input logic lv, input logic [W-1:0] d,
                             input logic sr, input logic co, input logic eo,
                             input logic ev, input logic el, input logic elr);
    vec_t v;
    v.rst = r; v.lv = lv; v.din = d; v.sr = sr; v.chk_out = co;
    v.eo = eo; v.ev = ev; v.el = el; v.elr = elr;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s v%0d actual=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  task automatic apply_vec(input int i);
    vec_t v;
    logic [1:0] e;
    v = vecs[i];
    @(negedge clk);
    rst = v.rst; load_valid = v.lv; data_in = v.din; ser_ready = v.sr;
    #1;
    if (i > 0) begin
      check("ser_valid", i, 32'(ser_valid), 32'(v.ev));
      check("ser_last", i, 32'(ser_last), 32'(v.el));
      check("load_ready", i, 32'(load_ready), 32'(v.elr));
      if (v.chk_out) check("ser_out", i, 32'(ser_out), 32'(v.eo));
    end
    if (v.rst) begin
      exp_q.delete();
    end else begin
      if (v.ev && v.sr) begin
        if (exp_q.size() == 0) begin
          check("sb_extra_bit", i, 32'(1), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check("sb_bit", i, 32'(ser_out), 32'(e[0]));
          check("sb_last", i, 32'(ser_last), 32'(e[1]));
        end
      end
      if (v.lv && v.elr) begin
        for (int b = 0; b < W; b++) exp_q.push_back({(b == W - 1), v.din[b]});
      end
    end
  endtask

  initial begin
    // ---- vector table: rst lv din sr | chk_out out valid last lready ----
    av(1, 0, 5'b00000, 0, 0, 0, 0, 0, 0);
    av(0, 0, 5'b00000, 1, 1, 0, 0, 0, 1);   // reset state
    // word 10110, ready held high
    av(0, 1, 5'b10110, 1, 0, 0, 0, 0, 1);
    av(0, 0, 5'b00000, 1, 1, 0, 1, 0, 0);
    av(0, 0, 5'b00000, 1, 1, 1, 1, 0, 0);
    av(0, 0, 5'b00000, 1, 1, 1, 1, 0, 0);
    av(0, 0, 5'b00000, 1, 1, 0, 1, 0, 0);
    av(0, 0, 5'b00000, 1, 1, 1, 1, 1, 1);
    av(0, 0, 5'b00000, 1, 0, 0, 0, 0, 1);
    // same word, ready 1,0,0,1,1,0,1,1
    av(0, 1, 5'b10110, 0, 0, 0, 0, 0, 1);
    av(0, 0, 5'b00000, 1, 1, 0, 1, 0, 0);
    av(0, 0, 5'b00000, 0, 1, 1, 1, 0, 0);
    av(0, 0, 5'b00000, 0, 1, 1, 1, 0, 0);
    av(0, 0, 5'b00000, 1, 1, 1, 1, 0, 0);
    av(0, 0, 5'b00000, 1, 1, 1, 1, 0, 0);
    av(0, 0, 5'b00000, 0, 1, 0, 1, 0, 0);
    av(0, 0, 5'b00000, 1, 1, 0, 1, 0, 0);
    av(0, 0, 5'b00000, 1, 1, 1, 1, 1, 1);
    av(0, 0, 5'b00000, 0, 0, 0, 0, 0, 1);
    // back-to-back 00001 then 11110, load_valid held high
    av(0, 1, 5'b00001, 1, 0, 0, 0, 0, 1);
    av(0, 1, 5'b11110, 1, 1, 1, 1, 0, 0);
    av(0, 1, 5'b11110, 1, 1, 0, 1, 0, 0);
    av(0, 1, 5'b11110, 1, 1, 0, 1, 0, 0);
    av(0, 1, 5'b11110, 1, 1, 0, 1, 0, 0);
    av(0, 1, 5'b11110, 1, 1, 0, 1, 1, 1);
    av(0, 0, 5'b00000, 1, 1, 0, 1, 0, 0);
    av(0, 0, 5'b00000, 1, 1, 1, 1, 0, 0);
    av(0, 0, 5'b00000, 1, 1, 1, 1, 0, 0);
    av(0, 0, 5'b00000, 1, 1, 1, 1, 0, 0);
    av(0, 0, 5'b00000, 1, 1, 1, 1, 1, 1);
    av(0, 0, 5'b00000, 1, 0, 0, 0, 0, 1);
    // 00000 with an ignored 11111 offered during bit 2
    av(0, 1, 5'b00000, 1, 0, 0, 0, 0, 1);
    av(0, 0, 5'b00000, 1, 1, 0, 1, 0, 0);
    av(0, 0, 5'b00000, 1, 1, 0, 1, 0, 0);
    av(0, 1, 5'b11111, 1, 1, 0, 1, 0, 0);
    av(0, 0, 5'b00000, 1, 1, 0, 1, 0, 0);
    av(0, 0, 5'b00000, 1, 1, 0, 1, 1, 1);
    av(0, 0, 5'b00000, 1, 1, 0, 0, 0, 1);
    // reset at bit 3 of 10101, then 01010
    av(0, 1, 5'b10101, 1, 0, 0, 0, 0, 1);
    av(0, 0, 5'b00000, 1, 1, 1, 1, 0, 0);
    av(0, 0, 5'b00000, 1, 1, 0, 1, 0, 0);
    av(0, 0, 5'b00000, 1, 1, 1, 1, 0, 0);
    av(1, 0, 5'b00000, 1, 1, 0, 1, 0, 0);
    av(0, 0, 5'b00000, 1, 1, 0, 0, 0, 1);
    av(0, 1, 5'b01010, 1, 1, 0, 0, 0, 1);
    av(0, 0, 5'b00000, 1, 1, 0, 1, 0, 0);
    av(0, 0, 5'b00000, 1, 1, 1, 1, 0, 0);
    av(0, 0, 5'b00000, 1, 1, 0, 1, 0, 0);
    av(0, 0, 5'b00000, 1, 1, 1, 1, 0, 0);
    av(0, 0, 5'b00000, 1, 1, 0, 1, 1, 1);
    // reset beats a pending load
    av(1, 1, 5'b11111, 1, 0, 0, 0, 0, 1);
    av(0, 0, 5'b00000, 1, 1, 0, 0, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      apply_vec(i);
      if (i == 1) begin
        check("dbg_state_reset", i, 32'(dbg_state), 32'(IDLE));
        check("dbg_cnt_reset", i, 32'(dbg_cnt), 32'(0));
      end
    end
    check("sb_empty", vecs.size(), 32'(exp_q.size()), 32'(0));

    @(negedge clk);
    rst = 1'b0; load_valid = 1'b0; ser_ready = 1'b0;

    // ---- WIDTH=1: loads 1 then 0 back-to-back, ready high ----
    @(negedge clk);
    rst1 = 1'b0; load_valid1 = 1'b1; data_in1 = 1'b1; ser_ready1 = 1'b1;
    #1;
    check("w1_idle_valid", 100, 32'(ser_valid1), 32'(0));
    check("w1_idle_lready", 100, 32'(load_ready1), 32'(1));
    @(negedge clk);
    data_in1 = 1'b0;
    #1;
    check("w1_b0_out", 101, 32'(ser_out1), 32'(1));
    check("w1_b0_valid", 101, 32'(ser_valid1), 32'(1));
    check("w1_b0_last", 101, 32'(ser_last1), 32'(1));
    check("w1_b0_lready", 101, 32'(load_ready1), 32'(1));
    @(negedge clk);
    load_valid1 = 1'b0;
    #1;
    check("w1_b1_out", 102, 32'(ser_out1), 32'(0));
    check("w1_b1_valid", 102, 32'(ser_valid1), 32'(1));
    check("w1_b1_last", 102, 32'(ser_last1), 32'(1));
    check("w1_b1_lready", 102, 32'(load_ready1), 32'(1));
    @(negedge clk);
    #1;
    check("w1_end_valid", 103, 32'(ser_valid1), 32'(0));
    check("w1_end_lready", 103, 32'(load_ready1), 32'(1));
    // WIDTH=1 with ready low: bit held, load_ready drops
    load_valid1 = 1'b1; data_in1 = 1'b1; ser_ready1 = 1'b0;
    @(negedge clk);
    load_valid1 = 1'b0;
    #1;
    check("w1_stall_out", 104, 32'(ser_out1), 32'(1));
    check("w1_stall_last", 104, 32'(ser_last1), 32'(1));
    check("w1_stall_lready", 104, 32'(load_ready1), 32'(0));
    @(negedge clk);
    #1;
    check("w1_stall2_valid", 105, 32'(ser_valid1), 32'(1));
    ser_ready1 = 1'b1;
    #1;
    check("w1_release_lready", 105, 32'(load_ready1), 32'(1));
    @(negedge clk);
    #1;
    check("w1_done_valid", 106, 32'(ser_valid1), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_serializer.md
# shift_serializer

Parallel-in, serial-out transmitter that takes a WIDTH-bit word from an upstream parallel register stage and emits it one bit per accepted cycle, LSB first. It uses a valid/ready handshake on both sides. It sits at the output side of the datapath, downstream of the parallel-load register bank. It drives any serial consumer that can apply backpressure.

## Interface
- WIDTH, default 5: word width in bits; legal range is WIDTH >= 1.
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- load_valid  input  1  upstream presents a word on data_in.
- load_ready  output  1  block can accept a word this cycle.
- data_in  input  WIDTH  parallel word; sampled only on a load handshake.
- ser_out  output  1  current serial bit.
- ser_valid  output  1  ser_out holds a valid bit.
- ser_last  output  1  current bit is bit WIDTH-1 of the word.
- ser_ready  input  1  downstream accepts the current bit this cycle.

## Operation
- States:
  - IDLE: no word held.
  - SHIFT: a word is held and bits are being emitted.
- Internal state:
  - shift register sreg[WIDTH-1:0].
  - bit counter cnt, width max(1, clog2(WIDTH)).
- Load handshake: load_valid && load_ready at an edge.
  - sreg <= data_in, cnt <= 0, state <= SHIFT.
- Bit handshake: ser_valid && ser_ready at an edge.
  - If not last: sreg shifts right by one (a 0 enters the MSB) and cnt increments.
  - If last with no simultaneous load: state <= IDLE.
- ser_out = sreg[0]; ser_valid = (state == SHIFT); ser_last = ser_valid && (cnt == WIDTH-1).
- load_ready = (state == IDLE) || (ser_valid && ser_ready && ser_last). This lets a new word load in the same cycle the last bit is consumed.
- Simultaneous last-bit accept and load: the load wins. sreg is reloaded, cnt <= 0, and state stays SHIFT, so there is no bubble.
- ser_ready low: sreg, cnt and state hold, and ser_out stays stable.
- load_valid while busy (not the last accepted bit): ignored. data_in is not sampled.
- WIDTH == 1: every emitted bit has ser_last = 1, and load_ready depends only on IDLE or on the current bit being consumed.
- Bits are never dropped or duplicated under any ready pattern.

## Timing
- Reset (rst high at an edge) gives: state = IDLE, sreg = 0, cnt = 0, ser_out = 0, ser_valid = 0, ser_last = 0, load_ready = 1.
- rst overrides every other input in the same cycle, including a pending load or bit accept.
- Reset mid-word aborts the word. Its remaining bits are discarded and never emitted.
- Latency: a load accepted at edge N puts bit 0 on ser_out with ser_valid = 1 immediately after edge N.
- With ser_ready held high, the word takes exactly WIDTH cycles.
- Sustained throughput with back-to-back loads is one bit per cycle with no idle gaps.
- load_ready, ser_valid and ser_last are combinational from registered state plus ser_ready. No combinational path exists from load_valid or data_in to any output.

## Structure
- Shared package/include holds:
  - the state encoding, IDLE = 1'b0 and SHIFT = 1'b1;
  - the counter-width constant function max(1, clog2(WIDTH)).
- Sub-module bit_counter: modulo-WIDTH up-counter.
  - Ports: clk, rst, clr, inc; outputs count and term (count == WIDTH-1).
  - clr has priority over inc.
- The top level holds the FSM, sreg and the handshake logic.

## Test plan
- WIDTH=5, load 5'b10110, ser_ready held high -> ser_out = 0,1,1,0,1 on 5 consecutive cycles. ser_last is high only on the 5th. Then ser_valid = 0 and load_ready = 1.
- Same word, ser_ready toggling 1,0,0,1,1,0,1,1 -> same 5-bit sequence. ser_out is stable while ser_ready = 0. Bits are accepted only on ready cycles.
- Back-to-back loads 5'b00001 then 5'b11110, load_valid high throughout -> 10 contiguous bits 1,0,0,0,0,0,1,1,1,1. The second load is accepted on the cycle ser_last is consumed.
- load_valid with data_in = 5'b11111 asserted during bit 2 of 5'b00000 -> load_ready = 0 and the word is ignored. The output stream is all zeros and no extra bits appear.
- rst asserted at bit 3 of 5'b10101 -> next cycle ser_valid = 0, ser_out = 0, load_ready = 1. A new load 5'b01010 then emits 0,1,0,1,0 from bit 0.
- WIDTH=1, loads 1 then 0 back-to-back with ser_ready high -> ser_out = 1,0, with ser_last = 1 on both cycles and load_ready = 1 every cycle.
